mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one signed multiplicator instance (DATA_WIDTH x DATA_WIDTH -> DATA_WIDTH_OUT) among NUM_REQ requesters.
//  Round-robin arbitration, valid/ready handshake on each request port and on the single response port.
//  Operands and products are registered. Each response is tagged with the index of the requester that issued it.
//  Sits between the compute clients and the multiplier datapath.
// PARAMETERS
//  DATA_WIDTH      8                 operand width (signed two's complement)
//  DATA_WIDTH_OUT  2*DATA_WIDTH      product width
//  NUM_REQ         4                 number of requesters, >=1
//  ID_WIDTH        $clog2(NUM_REQ)   requester-index width (1 when NUM_REQ==1)
// PORTS
//  clk_i          in   1                    clock, all logic on rising edge
//  rst_n_i        in   1                    synchronous reset, active-low
//  req_valid_i    in   NUM_REQ              bit k: requester k holds a valid operand pair
//  req_A_i        in   NUM_REQ*DATA_WIDTH   packed; slice [k*DATA_WIDTH +: DATA_WIDTH] = A of requester k
//  req_B_i        in   NUM_REQ*DATA_WIDTH   packed; same slicing for B
//  req_ready_o    out  NUM_REQ              grant; at most one bit high (one-hot or zero)
//  rsp_valid_o    out  1                    product valid
//  rsp_id_o       out  ID_WIDTH             index of the requester that owns rsp_product_o
//  rsp_product_o  out  DATA_WIDTH_OUT       signed product A*B
//  rsp_ready_i    in   1                    consumer accepts the response
// BEHAVIOUR
//  Reset (rst_n_i==0 at clk edge):
//   - state=IDLE, rr_ptr=0, rsp_valid_o=0, rsp_id_o=0, rsp_product_o=0, operand regs=0.
//   - req_ready_o=0 while rst_n_i==0.
//   - Reset mid-operation discards the in-flight transaction; no response is produced for it.
//  FSM: IDLE -> MULT -> RESP -> IDLE.
//   IDLE:
//    - req_ready_o is combinational: one-hot for the winner when any req_valid_i bit is set, else 0.
//    - Winner = first k with req_valid_i[k]=1, searching rr_ptr, rr_ptr+1, ..., NUM_REQ-1, then 0, ... (wraps).
//    - On a grant: latch the winner's A, B and id; rr_ptr <= (winner==NUM_REQ-1) ? 0 : winner+1; go to MULT.
//    - No valid request: stay in IDLE.
//   MULT (1 cycle):
//    - rsp_product_o <= signed(A)*signed(B); rsp_id_o <= latched id; rsp_valid_o <= 1; go to RESP.
//   RESP:
//    - rsp_valid_o=1; rsp_product_o and rsp_id_o held stable.
//    - rsp_valid_o && rsp_ready_i: rsp_valid_o <= 0, go to IDLE.
//    - Otherwise hold (backpressure) for as many cycles as needed.
//   req_ready_o=0 in MULT and RESP.
//  Latency and throughput:
//   - Grant at edge T -> rsp_valid_o high from T+2.
//   - With rsp_ready_i=1, at most one grant every 3 cycles.
//  Arithmetic:
//   - Full signed product.
//   - DATA_WIDTH_OUT < 2*DATA_WIDTH: keep the low DATA_WIDTH_OUT bits.
//   - DATA_WIDTH_OUT > 2*DATA_WIDTH: sign-extend.
//  Requester rule:
//   - Hold req_valid_i, A and B stable until the ready bit is seen.
//   - Dropping valid before the grant is legal; the request is simply not served.
//  Simultaneous events:
//   - Several valid requests: only the round-robin winner is granted.
//   - Requests arriving during MULT/RESP wait; no grant is lost or duplicated.
//  NUM_REQ==1: rr_ptr stays 0 and req_ready_o[0] follows req_valid_i[0] in IDLE.
// TESTING
//  1. Basic request: req0 A=3, B=-4 (8'hFC), rsp_ready_i=1
//     -> req_ready_o=4'b0001 at T; rsp_valid_o at T+2; product=16'hFFF4, id=0.
//  2. Extremes: A=-128, B=-128 -> 16'h4000; A=127, B=-128 -> 16'hC080; A=0, B=-1 -> 16'h0000.
//  3. Fairness: all 4 requesters valid continuously, rsp_ready_i=1
//     -> grants to 0,1,2,3,0 exactly 3 cycles apart; ids match the grant order.
//  4. Backpressure: rsp_ready_i=0 for 5 cycles after rsp_valid_o rises
//     -> product and id stable, req_ready_o=0 throughout.
//     -> After release: IDLE next cycle, then the next grant.
//  5. Wrap: after a grant to 2 (rr_ptr=3), requests on 1 and 3 -> grant 3 first, then 1.
//  6. Reset in MULT: rst_n_i=0 for one cycle
//     -> all outputs 0, rr_ptr=0, no response for the dropped operands, new request served normally.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one registered signed multiplier among NUM_REQ requesters.
// Each response carries the index of the requester that issued the operands.
//
//   state | meaning
//   IDLE  | grant the round-robin winner, latch its operands and id
//   MULT  | register the product and id, raise rsp_valid_o
//   RESP  | hold the response until rsp_ready_i
module mult_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_WIDTH_OUT = 2*DATA_WIDTH,
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_A_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_B_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          rsp_valid_o,
  output logic [ID_WIDTH-1:0]           rsp_id_o,
  output logic [DATA_WIDTH_OUT-1:0]     rsp_product_o,
  input  logic                          rsp_ready_i
);

  typedef enum logic [1:0] {IDLE, MULT, RESP} state_t;

  localparam int SW = ID_WIDTH + 1;

  state_t                      state_q, state_d;
  logic [ID_WIDTH-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]         id_q, id_d;
  logic [DATA_WIDTH-1:0]       op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]       op_b_q, op_b_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [ID_WIDTH-1:0]         rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH_OUT-1:0]   rsp_product_q, rsp_product_d;

  logic                        found;
  logic [ID_WIDTH-1:0]         winner;
  logic [NUM_REQ-1:0]          grant;
  logic [DATA_WIDTH-1:0]       a_sel, b_sel;
  logic signed [2*DATA_WIDTH-1:0] prod_full;
  logic [DATA_WIDTH_OUT-1:0]   prod_fit;

  // Search starts at rr_ptr and wraps; the sum is reduced modulo NUM_REQ by one subtraction.
  always_comb begin
    logic [SW-1:0]       sum;
    logic [ID_WIDTH-1:0] idx;
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + SW'(i);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      idx = sum[ID_WIDTH-1:0];
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == ID_WIDTH'(k)) begin
        a_sel = req_A_i[k*DATA_WIDTH +: DATA_WIDTH];
        b_sel = req_B_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant       = found ? (NUM_REQ'(1) << winner) : '0;
  assign req_ready_o = (rst_n_i && state_q == IDLE) ? grant : '0;

  // Size casts of signed values sign-extend, or keep the low bits when narrowing.
  assign prod_full = (2*DATA_WIDTH)'($signed(op_a_q)) * (2*DATA_WIDTH)'($signed(op_b_q));
  assign prod_fit  = DATA_WIDTH_OUT'(prod_full);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          op_a_d   = a_sel;
          op_b_d   = b_sel;
          id_d     = winner;
          rr_ptr_d = (winner == ID_WIDTH'(NUM_REQ-1)) ? '0 : winner + ID_WIDTH'(1);
          state_d  = MULT;
        end
      end
      MULT: begin
        rsp_product_d = prod_fit;
        rsp_id_d      = id_q;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = rsp_id_q;
  assign rsp_product_o = rsp_product_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: handshake timing, signed products, round-robin order,
// backpressure and reset mid-transaction, all against hand-computed values.
module tb_mult_arbiter;
  localparam int DW  = 8;
  localparam int DWO = 16;
  localparam int NR  = 4;
  localparam int IW  = 2;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR*DW-1:0]  req_A_i;
  logic [NR*DW-1:0]  req_B_i;
  logic [NR-1:0]     req_ready_o;
  logic              rsp_valid_o;
  logic [IW-1:0]     rsp_id_o;
  logic [DWO-1:0]    rsp_product_o;
  logic              rsp_ready_i;

  int total = 0;
  int bad   = 0;

  mult_arbiter #(.DATA_WIDTH(DW), .DATA_WIDTH_OUT(DWO), .NUM_REQ(NR)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req_valid_i  (req_valid_i),
    .req_A_i      (req_A_i),
    .req_B_i      (req_B_i),
    .req_ready_o  (req_ready_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_product_o(rsp_product_o),
    .rsp_ready_i  (rsp_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
    req_A_i[k*DW +: DW] = a;
    req_B_i[k*DW +: DW] = b;
  endtask

  // Called at a negedge in IDLE; ends at the negedge of the following IDLE cycle.
  task automatic txn(input int k, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] p, input logic [3:0] g);
    set_ops(k, a, b);
    req_valid_i[k] = 1'b1;
    #1 chk("grant", req_ready_o, g);
    @(negedge clk_i);
    req_valid_i[k] = 1'b0;
    #1;
    chk("mult_ready", req_ready_o, 0);
    chk("mult_valid", rsp_valid_o, 0);
    @(negedge clk_i);
    chk("rsp_valid", rsp_valid_o, 1);
    chk("rsp_product", rsp_product_o, p);
    chk("rsp_id", rsp_id_o, k);
    @(negedge clk_i);
    chk("idle_valid", rsp_valid_o, 0);
  endtask

  logic [7:0]  fa [4] = '{8'h02, 8'h03, 8'h04, 8'h05};
  logic [15:0] fp [4] = '{16'hFFFA, 16'hFFF7, 16'hFFF4, 16'hFFF1};

  initial begin
    rst_n_i     = 1'b0;
    req_valid_i = 4'b1111;
    req_A_i     = '0;
    req_B_i     = '0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_id", rsp_id_o, 0);
    chk("rst_product", rsp_product_o, 0);
    rst_n_i     = 1'b1;
    req_valid_i = '0;
    @(negedge clk_i);
    chk("idle_no_req", req_ready_o, 0);

    // basic and extreme operands; rr_ptr ends at 0
    txn(0, 8'h03, 8'hFC, 16'hFFF4, 4'b0001);
    txn(1, 8'h80, 8'h80, 16'h4000, 4'b0010);
    txn(2, 8'h7F, 8'h80, 16'hC080, 4'b0100);
    txn(3, 8'h00, 8'hFF, 16'h0000, 4'b1000);

    // fairness: all four valid, grants exactly three cycles apart
    for (int k = 0; k < 4; k++) set_ops(k, fa[k], 8'hFD);
    req_valid_i = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("rr_grant", req_ready_o, 4'b0001 << (g % 4));
      @(negedge clk_i);
      chk("rr_mult_ready", req_ready_o, 0);
      @(negedge clk_i);
      chk("rr_valid", rsp_valid_o, 1);
      chk("rr_id", rsp_id_o, g % 4);
      chk("rr_product", rsp_product_o, fp[g % 4]);
      chk("rr_resp_ready", req_ready_o, 0);
      @(negedge clk_i);
      if (g == 4) req_valid_i = '0;
      #1;
    end
    chk("rr_idle_ready", req_ready_o, 0);
    @(negedge clk_i);

    // backpressure on requester 1 (rr_ptr=1) while requester 2 waits
    set_ops(1, 8'hFB, 8'h07);
    req_valid_i[1] = 1'b1;
    rsp_ready_i    = 1'b0;
    #1 chk("bp_grant", req_ready_o, 4'b0010);
    @(negedge clk_i);
    req_valid_i[1] = 1'b0;
    set_ops(2, 8'h06, 8'h06);
    req_valid_i[2] = 1'b1;
    @(negedge clk_i);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", rsp_valid_o, 1);
      chk("bp_product", rsp_product_o, 16'hFFDD);
      chk("bp_id", rsp_id_o, 1);
      chk("bp_ready", req_ready_o, 0);
      @(negedge clk_i);
    end
    chk("bp_hold_valid", rsp_valid_o, 1);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_release_valid", rsp_valid_o, 0);
    chk("bp_next_grant", req_ready_o, 4'b0100);
    @(negedge clk_i);
    req_valid_i[2] = 1'b0;
    @(negedge clk_i);
    chk("bp2_product", rsp_product_o, 16'h0024);
    chk("bp2_id", rsp_id_o, 2);
    @(negedge clk_i);

    // wrap: rr_ptr=3 with requests on 1 and 3
    set_ops(1, 8'h02, 8'h05);
    set_ops(3, 8'hFF, 8'hFF);
    req_valid_i = 4'b1010;
    #1 chk("wrap_first", req_ready_o, 4'b1000);
    @(negedge clk_i);
    req_valid_i[3] = 1'b0;
    @(negedge clk_i);
    chk("wrap_prod3", rsp_product_o, 16'h0001);
    chk("wrap_id3", rsp_id_o, 3);
    @(negedge clk_i);
    chk("wrap_second", req_ready_o, 4'b0010);
    @(negedge clk_i);
    req_valid_i[1] = 1'b0;
    @(negedge clk_i);
    chk("wrap_prod1", rsp_product_o, 16'h000A);
    chk("wrap_id1", rsp_id_o, 1);
    @(negedge clk_i);

    // reset while in MULT drops the transaction and clears rr_ptr
    set_ops(0, 8'h09, 8'h09);
    req_valid_i[0] = 1'b1;
    #1 chk("rm_grant", req_ready_o, 4'b0001);
    @(negedge clk_i);
    req_valid_i = 4'b1000;
    rst_n_i     = 1'b0;
    #1 chk("rm_ready_in_rst", req_ready_o, 0);
    @(negedge clk_i);
    rst_n_i     = 1'b1;
    req_valid_i = '0;
    chk("rm_valid", rsp_valid_o, 0);
    chk("rm_product", rsp_product_o, 0);
    chk("rm_id", rsp_id_o, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("rm_no_rsp", rsp_valid_o, 0);
    end
    set_ops(3, 8'h11, 8'h02);
    req_valid_i[3] = 1'b1;
    txn(0, 8'hF9, 8'h03, 16'hFFEB, 4'b0001);
    req_valid_i = '0;
    @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
